// File: rtl/shared_counter_arbiter_if.sv
// Requester-side bundle of the shared counter arbiter: level requests and targets in,
// exclusive grant, run status and completion report out.
interface shared_counter_arbiter_if #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = 4,
    parameter int unsigned IDW   = $clog2(N_REQ)
);
    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] len;
    logic [N_REQ-1:0]       grant;
    logic                   busy;
    logic [WIDTH-1:0]       count;
    logic                   done;
    logic [IDW-1:0]         done_id;

    modport master (output req, len, input grant, busy, count, done, done_id);
    modport slave  (input req, len, output grant, busy, count, done, done_id);
endinterface

// File: rtl/shared_counter_arbiter.sv
// Round-robin arbiter that lends one up-counter to N_REQ requesters, one run at a time,
// counting 0..target for the winner and pulsing done with the winner's index.
module shared_counter_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = 4,
    parameter int unsigned IDW   = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    reset,
    shared_counter_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   win_q, win_d;
    logic [IDW-1:0]   done_id_q, done_id_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             found_c;
    logic [IDW-1:0]   pick_c;
    logic [IDW-1:0]   idx_c;
    logic [IDW-1:0]   ptr_next_c;
    logic [WIDTH-1:0] len_arr [N_REQ];

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_len
        assign len_arr[gi] = bus.len[gi*WIDTH +: WIDTH];
    end

    // First requester at or after ptr, wrapping modulo N_REQ
    always_comb begin
        found_c = 1'b0;
        pick_c  = ptr_q;
        idx_c   = ptr_q;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx_c = IDW'((32'(ptr_q) + k) % N_REQ);
            if (!found_c && bus.req[idx_c]) begin
                found_c = 1'b1;
                pick_c  = idx_c;
            end
        end
    end

    assign ptr_next_c = (win_q == IDW'(N_REQ - 1)) ? '0 : win_q + IDW'(1);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        win_d     = win_q;
        done_id_d = done_id_q;
        target_d  = target_q;
        count_d   = count_q;
        grant_d   = grant_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (found_c) begin
                    win_d           = pick_c;
                    target_d        = len_arr[pick_c];
                    grant_d         = '0;
                    grant_d[pick_c] = 1'b1;
                    busy_d          = 1'b1;
                    count_d         = '0;
                    state_d         = S_RUN;
                end
            end
            S_RUN: begin
                // Completion outranks a simultaneous request drop
                if (count_q == target_q) begin
                    grant_d   = '0;
                    busy_d    = 1'b0;
                    count_d   = '0;
                    done_d    = 1'b1;
                    done_id_d = win_q;
                    ptr_d     = ptr_next_c;
                    state_d   = S_DONE;
                end else if (!bus.req[win_q]) begin
                    grant_d = '0;
                    busy_d  = 1'b0;
                    count_d = '0;
                    ptr_d   = ptr_next_c;
                    state_d = S_IDLE;
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            win_q     <= '0;
            done_id_q <= '0;
            target_q  <= '0;
            count_q   <= '0;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            win_q     <= win_d;
            done_id_q <= done_id_d;
            target_q  <= target_d;
            count_q   <= count_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.grant   = grant_q;
    assign bus.busy    = busy_q;
    assign bus.count   = count_q;
    assign bus.done    = done_q;
    assign bus.done_id = done_id_q;
endmodule

// File: tb/tb_shared_counter_arbiter.sv
// Bench for shared_counter_arbiter: a vector table, directed corner sequences and a
// randomized run, all checked cycle by cycle against a run-level reference model.
module tb_shared_counter_arbiter;
    localparam int unsigned N   = 4;
    localparam int unsigned W   = 4;
    localparam int unsigned IDW = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    shared_counter_arbiter_if #(.N_REQ(N), .WIDTH(W), .IDW(IDW)) bus ();
    shared_counter_arbiter #(.N_REQ(N), .WIDTH(W), .IDW(IDW)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [W-1:0] lens [N];

    // Reference model: who owns the counter, how far it has counted, and rotation state
    int m_owner, m_cnt, m_tgt, m_ptr, m_done_id;
    bit m_done, m_in_done;

    typedef struct {
        logic [3:0] req;
        logic [3:0] len0;
        logic [3:0] g;
        logic       b;
        logic [3:0] c;
        logic       d;
        logic [1:0] id;
    } vec_t;
    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic apply();
        bus.len = {lens[3], lens[2], lens[1], lens[0]};
    endtask

    task automatic model_reset();
        m_owner = -1; m_cnt = 0; m_tgt = 0; m_ptr = 0; m_done_id = 0;
        m_done = 0; m_in_done = 0;
    endtask

    task automatic model_step();
        if (m_in_done) begin
            m_in_done = 0;
            m_done    = 0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < int'(N); k++) begin
                int i;
                i = (m_ptr + k) % int'(N);
                if (bus.req[i]) begin
                    m_owner = i;
                    m_tgt   = int'(lens[i]);
                    m_cnt   = 0;
                    break;
                end
            end
        end else if (m_cnt == m_tgt) begin
            m_done    = 1;
            m_done_id = m_owner;
            m_ptr     = (m_owner + 1) % int'(N);
            m_owner   = -1;
            m_cnt     = 0;
            m_in_done = 1;
        end else if (!bus.req[m_owner]) begin
            m_ptr   = (m_owner + 1) % int'(N);
            m_owner = -1;
            m_cnt   = 0;
        end else begin
            m_cnt++;
        end
    endtask

    // One clock: advance the model with the inputs seen at the edge, then compare
    task automatic cyc();
        logic [31:0] eg;
        @(posedge clk);
        model_step();
        #1;
        eg = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
        chk("grant",   32'(bus.grant),   eg);
        chk("busy",    32'(bus.busy),    (m_owner >= 0) ? 32'd1 : 32'd0);
        chk("count",   32'(bus.count),   (m_owner >= 0) ? 32'(m_cnt) : 32'd0);
        chk("done",    32'(bus.done),    32'(m_done));
        chk("done_id", 32'(bus.done_id), 32'(m_done_id));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        #1;
        chk("rst_grant", 32'(bus.grant), 32'd0);
        chk("rst_busy",  32'(bus.busy),  32'd0);
        chk("rst_done",  32'(bus.done),  32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic run_one(output int gc, output int maxc, output bit seen);
        gc = 0; maxc = 0; seen = 0;
        for (int c = 0; c < 40 && !seen; c++) begin
            cyc();
            if (bus.grant != 0) gc++;
            if (int'(bus.count) > maxc) maxc = int'(bus.count);
            if (bus.done) seen = 1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int gc, maxc;
        bit seen;
        int ids[$];

        tbl[0] = '{4'b0001, 4'd3,  4'b0001, 1'b1, 4'd0, 1'b0, 2'd0};
        tbl[1] = '{4'b0001, 4'd15, 4'b0001, 1'b1, 4'd1, 1'b0, 2'd0};
        tbl[2] = '{4'b0001, 4'd15, 4'b0001, 1'b1, 4'd2, 1'b0, 2'd0};
        tbl[3] = '{4'b0001, 4'd15, 4'b0001, 1'b1, 4'd3, 1'b0, 2'd0};
        tbl[4] = '{4'b0001, 4'd3,  4'b0000, 1'b0, 4'd0, 1'b1, 2'd0};
        tbl[5] = '{4'b0001, 4'd3,  4'b0000, 1'b0, 4'd0, 1'b0, 2'd0};
        tbl[6] = '{4'b0001, 4'd3,  4'b0001, 1'b1, 4'd0, 1'b0, 2'd0};
        tbl[7] = '{4'b0001, 4'd3,  4'b0001, 1'b1, 4'd1, 1'b0, 2'd0};
        tbl[8] = '{4'b0000, 4'd3,  4'b0000, 1'b0, 4'd0, 1'b0, 2'd0};
        tbl[9] = '{4'b0000, 4'd3,  4'b0000, 1'b0, 4'd0, 1'b0, 2'd0};

        reset   = 1'b1;
        bus.req = '0;
        for (int i = 0; i < int'(N); i++) lens[i] = '0;
        apply();
        model_reset();
        #12;
        chk("reset_grant",   32'(bus.grant),   32'd0);
        chk("reset_busy",    32'(bus.busy),    32'd0);
        chk("reset_count",   32'(bus.count),   32'd0);
        chk("reset_done",    32'(bus.done),    32'd0);
        chk("reset_done_id", 32'(bus.done_id), 32'd0);
        reset = 1'b0;

        // Single requester, target 3, with len wiggling mid-run
        for (int i = 0; i < 10; i++) begin
            bus.req = tbl[i].req;
            lens[0] = tbl[i].len0;
            apply();
            cyc();
            chk("tbl_grant",   32'(bus.grant),   32'(tbl[i].g));
            chk("tbl_busy",    32'(bus.busy),    32'(tbl[i].b));
            chk("tbl_count",   32'(bus.count),   32'(tbl[i].c));
            chk("tbl_done",    32'(bus.done),    32'(tbl[i].d));
            chk("tbl_done_id", 32'(bus.done_id), 32'(tbl[i].id));
        end

        // Round robin with everyone requesting and target 1
        do_reset();
        for (int i = 0; i < int'(N); i++) lens[i] = 4'd1;
        bus.req = 4'b1111;
        apply();
        for (int c = 0; c < 60 && ids.size() < 5; c++) begin
            cyc();
            if (bus.done) ids.push_back(int'(bus.done_id));
        end
        chk("rr_completions", 32'(ids.size()), 32'd5);
        for (int i = 0; i < ids.size(); i++) chk("rr_done_id", 32'(ids[i]), 32'(i % 4));

        // Boundary targets 0 and 15
        do_reset();
        lens[0] = 4'd0;
        bus.req = 4'b0001;
        apply();
        run_one(gc, maxc, seen);
        chk("len0_done_seen", 32'(seen), 32'd1);
        chk("len0_grant_cycles", 32'(gc), 32'd1);
        do_reset();
        lens[0] = 4'd15;
        apply();
        run_one(gc, maxc, seen);
        chk("len15_done_seen", 32'(seen), 32'd1);
        chk("len15_grant_cycles", 32'(gc), 32'd16);
        chk("len15_max_count", 32'(maxc), 32'd15);

        // Abort of requester 2 at count 4, then 3 must precede 1
        do_reset();
        lens[1] = 4'd1; lens[2] = 4'd10; lens[3] = 4'd1;
        bus.req = 4'b0100;
        apply();
        for (int c = 0; c < 30 && bus.count != 4'd4; c++) cyc();
        chk("abort_reach4", 32'(bus.count), 32'd4);
        bus.req = 4'b1010;
        cyc();
        chk("abort_grant_drop", 32'(bus.grant), 32'd0);
        chk("abort_no_done", 32'(bus.done), 32'd0);
        cyc();
        chk("abort_next_is_3", 32'(bus.grant), 32'b1000);
        seen = 0;
        for (int c = 0; c < 12 && !seen; c++) begin
            cyc();
            if (bus.grant == 4'b0010) seen = 1;
        end
        chk("abort_then_1", 32'(seen), 32'd1);

        // Request drops in the cycle count reaches target: completion still reported
        do_reset();
        lens[2] = 4'd2;
        bus.req = 4'b0100;
        apply();
        for (int c = 0; c < 20 && bus.count != 4'd2; c++) cyc();
        chk("sim_reach_target", 32'(bus.count), 32'd2);
        bus.req = 4'b0000;
        cyc();
        chk("sim_done", 32'(bus.done), 32'd1);
        chk("sim_done_id", 32'(bus.done_id), 32'd2);
        cyc();

        // Asynchronous reset mid-run, then arbitration restarts from requester 0
        do_reset();
        lens[0] = 4'd10;
        bus.req = 4'b0001;
        apply();
        for (int c = 0; c < 20 && bus.count != 4'd5; c++) cyc();
        chk("ar_reach5", 32'(bus.count), 32'd5);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("ar_grant", 32'(bus.grant), 32'd0);
        chk("ar_busy",  32'(bus.busy),  32'd0);
        chk("ar_count", 32'(bus.count), 32'd0);
        chk("ar_done",  32'(bus.done),  32'd0);
        bus.req = 4'b0110;
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc();
        chk("ar_first_grant", 32'(bus.grant), 32'b0010);

        // Randomized traffic against the model
        do_reset();
        bus.req = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < int'(N); i++) begin
                if ($urandom_range(0, 7) == 0) bus.req[i] = ~bus.req[i];
                lens[i] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15))
                                                      : 4'($urandom_range(0, 4));
            end
            apply();
            if ($urandom_range(0, 599) == 0) do_reset();
            else cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
